// File: rtl/multi_channel_handshake_rx.sv
// multi_channel_handshake_rx: NUM_CH-way 4-phase req/ack receiver with
// round-robin grant, one-entry valid/ready output register, release
// timeout and completed-transfer counter.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req          per-channel request
//   data_in      channel i word at [i*DATA_W +: DATA_W]
//   ack          per-channel acknowledge (one-hot or zero)
//   ready        per-channel "may request" (all bits equal)
//   out_data     captured word
//   out_ch       source channel of out_data
//   out_valid    out_data/out_ch valid
//   out_ready    consumer accept
//   timeout_err  one-cycle pulse when a release times out
//   err_ch       channel of the last timeout
//   xfer_count   completed handshakes (wraps)
module multi_channel_handshake_rx #(
    parameter int DATA_W  = 8,
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH*DATA_W-1:0]  data_in,
    output logic [NUM_CH-1:0]         ack,
    output logic [NUM_CH-1:0]         ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      timeout_err,
    output logic [$clog2(NUM_CH)-1:0] err_ch,
    output logic [15:0]               xfer_count
);

    localparam int CW    = $clog2(NUM_CH);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     g;
    logic [CW-1:0]     last_grant;
    logic [CNT_W-1:0]  cnt;

    logic              space;
    logic              found;
    logic [CW-1:0]     win;
    int                idx;
    logic [CW-1:0]     idx_c;

    assign space = !out_valid || out_ready;
    assign ready = {NUM_CH{(state == IDLE) && space}};

    // Scan from the channel after last_grant, wrapping; the first
    // requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_c = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            idx_c = idx[CW-1:0];
            if (!found && req[idx_c]) begin
                found = 1'b1;
                win   = idx_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            g           <= '0;
            last_grant  <= CW'(NUM_CH - 1);
            cnt         <= '0;
            ack         <= '0;
            out_data    <= '0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
            err_ch      <= '0;
            xfer_count  <= '0;
        end else begin
            timeout_err <= 1'b0;
            // A grant below overrides this clear in the same cycle.
            if (out_valid && out_ready) out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found && space) begin
                        g         <= win;
                        out_data  <= data_in[int'(win)*DATA_W +: DATA_W];
                        out_ch    <= win;
                        out_valid <= 1'b1;
                        ack       <= {{(NUM_CH-1){1'b0}}, 1'b1} << win;
                        cnt       <= '0;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    if (!req[g]) begin
                        ack        <= '0;
                        xfer_count <= xfer_count + 16'd1;
                        last_grant <= g;
                        state      <= IDLE;
                    end else if (TO_EN && cnt == CNT_LAST) begin
                        ack         <= '0;
                        timeout_err <= 1'b1;
                        err_ch      <= g;
                        state       <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!req[g]) begin
                        last_grant <= g;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_handshake_rx.sv
// tb_multi_channel_handshake_rx: directed scenarios with a scoreboard
// queue of expected {out_ch,out_data} words checked by a monitor.
module tb_multi_channel_handshake_rx;

    localparam int DW = 8;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     req;
    logic [NC*DW-1:0]  data_in;
    logic [NC-1:0]     ack;
    logic [NC-1:0]     ready;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              timeout_err;
    logic [CW-1:0]     err_ch;
    logic [15:0]       xfer_count;

    int checks = 0;
    int failures = 0;
    logic [CW+DW-1:0] sb[$];

    multi_channel_handshake_rx #(
        .DATA_W(DW), .NUM_CH(NC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .ack(ack), .ready(ready), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .timeout_err(timeout_err),
        .err_ch(err_ch), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(int ch, logic [DW-1:0] v);
        data_in[ch*DW +: DW] = v;
    endtask

    task automatic push(int ch, logic [DW-1:0] v);
        logic [CW-1:0] c;
        c = CW'(ch);
        sb.push_back({c, v});
    endtask

    // Each negedge with valid&&ready is exactly one consumed word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got %0h expected none",
                         {out_ch, out_data});
            end else begin
                chk("sb_word", {22'd0, out_ch, out_data},
                    {22'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ah;
        int ord[5];
        ord = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req = '0;
        data_in = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_ack", ack, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_xfer", xfer_count, 0);
        chk("rst_terr", timeout_err, 0);
        rst = 1'b0;

        // Single transfer
        set_d(1, 8'hA5);
        req = 4'b0010;
        push(1, 8'hA5);
        tick();
        chk("t1_ack", ack, 4'b0010);
        req = 4'b0000;
        tick();
        chk("t1_ack_drop", ack, 0);
        chk("t1_xfer", xfer_count, 1);

        // Data change during ack
        out_ready = 1'b0;
        set_d(0, 8'h55);
        req = 4'b0001;
        push(0, 8'h55);
        tick();
        chk("t2_ack", ack, 4'b0001);
        set_d(0, 8'hAA);
        tick();
        chk("t2_hold", out_data, 8'h55);
        req = 4'b0000;
        tick();
        chk("t2_xfer", xfer_count, 2);
        out_ready = 1'b1;
        tick();

        // Round-robin after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NC; i++) set_d(i, 8'(8'h10 + i));
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            push(ord[i], 8'(8'h10 + ord[i]));
            tick();
            chk("rr_ack", ack, 32'(1) << ord[i]);
            chk("rr_onehot", ($countones(ack) <= 1), 1);
            req[ord[i]] = 1'b0;
            tick();
            chk("rr_drop", ack, 0);
            req[ord[i]] = 1'b1;
        end
        req = 4'b0000;
        tick();
        chk("rr_xfer", xfer_count, 5);

        // Backpressure
        out_ready = 1'b0;
        set_d(2, 8'h3C);
        req = 4'b0100;
        push(2, 8'h3C);
        tick();
        chk("bp_ack1", ack, 4'b0100);
        req = 4'b0000;
        tick();
        set_d(1, 8'h77);
        req = 4'b0010;
        #1;
        chk("bp_ready0", ready, 0);
        tick();
        chk("bp_noack", ack, 0);
        chk("bp_hold", {out_valid, out_data}, {1'b1, 8'h3C});
        tick();
        chk("bp_noack2", ack, 0);
        push(1, 8'h77);
        out_ready = 1'b1;
        #1;
        chk("bp_ready1", ready, 4'b1111);
        tick();
        chk("bp_ack2", ack, 4'b0010);
        req = 4'b0000;
        tick();
        chk("bp_xfer", xfer_count, 7);

        // Timeout
        set_d(2, 8'h99);
        set_d(1, 8'h44);
        req = 4'b0100;
        push(2, 8'h99);
        tick();
        ah = 0;
        if (ack == 4'b0100) ah = 1;
        req = 4'b0110;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack[2]) ah++;
            else break;
        end
        chk("to_ack_cycles", ah, TO);
        chk("to_pulse", timeout_err, 1);
        chk("to_err_ch", err_ch, 2);
        chk("to_xfer", xfer_count, 7);
        tick();
        chk("to_pulse_end", timeout_err, 0);
        chk("to_drain_ack", ack, 0);
        tick();
        chk("to_drain_ack2", ack, 0);
        req = 4'b0010;
        push(1, 8'h44);
        tick();
        chk("to_idle_ack", ack, 0);
        tick();
        chk("to_next_ack", ack, 4'b0010);
        req = 4'b0000;
        tick();
        chk("to_next_xfer", xfer_count, 8);
        chk("to_err_hold", err_ch, 2);

        // Reset mid-handshake; pending word is discarded
        out_ready = 1'b0;
        set_d(3, 8'hE1);
        req = 4'b1000;
        tick();
        chk("rm_ack", {ack, out_valid}, {4'b1000, 1'b1});
        rst = 1'b1;
        tick();
        chk("rm_ack0", ack, 0);
        chk("rm_outs", {out_valid, out_data, out_ch, err_ch, timeout_err},
            0);
        chk("rm_xfer", xfer_count, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        set_d(0, 8'h0F);
        req = 4'b1001;
        push(0, 8'h0F);
        tick();
        chk("rm_prio", ack, 4'b0001);
        req = 4'b0000;
        tick();
        tick();
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_channel_handshake_rx.md
# multi_channel_handshake_rx

Parametrised multi-channel 4-phase req/ack receiver. It accepts words from NUM_CH independent requesters, each using the req/ack handshake of the single-channel protocol block. Grants are arbitrated round-robin, and each granted word is forwarded through a one-entry valid/ready output register. A per-transaction release timeout and a completed-transfer counter are included. It sits between several producer-side handshake sources and one streaming consumer.

## Interface
Parameters:
- DATA_W, 8, width of each channel's data word
- NUM_CH, 4, number of requester channels (2..16)
- TIMEOUT, 16, max cycles ack is held waiting for req release; 0 disables the timeout

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_CH  per-channel request
- data_in  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- ack  out  NUM_CH  per-channel acknowledge, at most one bit high (one-hot or zero)
- ready  out  NUM_CH  per-channel "may request"; all bits equal
- out_data  out  DATA_W  captured word
- out_ch  out  $clog2(NUM_CH)  source channel of out_data
- out_valid  out  1  out_data/out_ch valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- timeout_err  out  1  one-cycle pulse on release timeout
- err_ch  out  $clog2(NUM_CH)  channel that timed out; holds until the next error
- xfer_count  out  16  completed handshakes, wraps 0xFFFF->0

## Operation
- Reset: the block is reset when rst is sampled high. All outputs go to 0, FSM goes to IDLE, the round-robin pointer is set so that ch0 has top priority, and the timeout counter is cleared. A word pending in the output register is discarded. Reset mid-handshake drops ack immediately.
- space = !out_valid || out_ready.
- ready[i] = (state==IDLE) && space, combinational.
- FSM states:
  - IDLE: grant when any req is high and space is true. The winner is the first requester at or after (last_grant+1) mod NUM_CH. On grant:
    - latch g
    - capture data_in[g] into out_data and set out_ch=g, out_valid=1
    - assert ack[g], clear the counter, go to ACK
  - ACK: ack[g] is held high.
    - If req[g] is low, drop ack, increment xfer_count, update last_grant=g, go to IDLE.
    - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1, go to DRAIN.
    - Otherwise, increment the counter.
  - DRAIN: ack is low. On entry, timeout_err pulses for one cycle and err_ch=g. Stay in DRAIN until req[g] is low, then go to IDLE with last_grant=g. xfer_count does not increment.
- Data is sampled only at the grant edge. Changes on data_in while in ACK or DRAIN are ignored.
- Requests from non-granted channels are held off (ready low) and are served in round-robin order afterwards.
- Output register:
  - An out_valid && out_ready handshake clears out_valid, unless a new grant loads the register in the same cycle; in that case out_valid stays 1 with the new word.
  - The delivered word is not retracted on timeout.

## Timing
- Grant latency: req[i] is sampled high at edge N with ready high. At edge N, ack[i]=1 and out_valid=1 with out_data=data_in[i] as sampled at edge N.
- Release: req[g] is sampled low at edge M. At edge M, ack=0 and state=IDLE. The earliest next grant is edge M+1, which gives a minimum of 2 cycles per transfer.
- Timeout: if req is never released, ack is high for exactly TIMEOUT cycles. timeout_err is high in the cycle after ack falls.
- Backpressure: while out_valid=1 and out_ready=0, ready stays 0 and no grant occurs. The grant happens in the same cycle that out_ready rises.
- Simultaneous req on all channels after reset: grant order is 0,1,2,3,0,...
- xfer_count increments at the edge where ack falls on a completed handshake.

## Test plan
- Single transfer: DATA_W=8, NUM_CH=4. After reset, send req[1] with data 0xA5 and hold out_ready=1 -> ack[1] next edge, out_data=0xA5, out_ch=1. Drop req -> ack low next edge, xfer_count=1.
- Data change during ack: grant ch0 with 0x55, then change data to 0xAA while ack is high -> out_data stays 0x55.
- Round-robin: hold all four req high and release each on ack -> grant order ch0,ch1,ch2,ch3,ch0, and ack is never multi-hot.
- Backpressure: out_ready=0, complete a transfer of 0x3C, then request again -> ready=0, no ack. Raise out_ready -> 0x3C is consumed and the new word is granted in the same cycle.
- Timeout: TIMEOUT=4, hold req[2] high indefinitely -> ack[2] high for 4 cycles, timeout_err pulses with err_ch=2, xfer_count unchanged, no new grant until req[2] drops.
- Reset mid-handshake: assert rst while ack[3]=1 and out_valid=1 -> next edge all outputs 0, and after release ch0 has top priority.
